// File: rtl/shift_rotate_reg_if.sv
// Signal bundle for shift_rotate_reg: control and data inputs plus register,
// serial-out and handshake outputs.
interface shift_rotate_reg_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             Clear;
    logic             Set;
    logic             Hold;
    logic             Load;
    logic [WIDTH-1:0] Data;
    logic             Start;
    logic [1:0]       Mode;
    logic [AMT_W-1:0] Amount;
    logic             SerIn;
    logic [WIDTH-1:0] Q;
    logic             SerOut;
    logic             Busy;
    logic             Done;

    modport master (
        output Clear, Set, Hold, Load, Data, Start, Mode, Amount, SerIn,
        input  Q, SerOut, Busy, Done
    );

    modport slave (
        input  Clear, Set, Hold, Load, Data, Start, Mode, Amount, SerIn,
        output Q, SerOut, Busy, Done
    );
endinterface

// File: rtl/shift_rotate_reg.sv
// General-purpose WIDTH-bit register with clear/set/hold/load and a sequenced
// shift/rotate engine that performs one single-bit step per clock.
module shift_rotate_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input logic               Clock,
    input logic               Reset,
    shift_rotate_reg_if.slave bus
);
    typedef enum logic [1:0] {SHL = 2'b00, SHR = 2'b01, ROL = 2'b10, ROR = 2'b11} mode_t;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, next_state;
    mode_t            mode_q, mode_eff;
    logic [WIDTH-1:0] q_r, step_q;
    logic [AMT_W-1:0] cnt, amt_sat;
    logic             done_r;
    logic             busy;
    logic             serout;

    assign amt_sat = (bus.Amount > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.Amount;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (bus.Clear || bus.Set) begin
            next_state = IDLE;
        end else if (!bus.Hold) begin
            case (state)
                IDLE:    if (!bus.Load && bus.Start && amt_sat != '0) next_state = SHIFT;
                SHIFT:   if (cnt == AMT_W'(1)) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // SerOut follows the live Mode while idle so the first ejected bit is visible before Start.
    always_comb begin
        busy     = (state == SHIFT);
        mode_eff = (state == IDLE) ? mode_t'(bus.Mode) : mode_q;
        serout   = (mode_eff == SHL || mode_eff == ROL) ? q_r[WIDTH-1] : q_r[0];
        step_q   = q_r;
        case (mode_q)
            SHL:     step_q = {q_r[WIDTH-2:0], bus.SerIn};
            SHR:     step_q = {bus.SerIn, q_r[WIDTH-1:1]};
            ROL:     step_q = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            ROR:     step_q = {q_r[0], q_r[WIDTH-1:1]};
            default: step_q = q_r;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q_r    <= '0;
            cnt    <= '0;
            mode_q <= SHL;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (bus.Clear) begin
                q_r <= '0;
                cnt <= '0;
            end else if (bus.Set) begin
                q_r <= '1;
                cnt <= '0;
            end else if (!bus.Hold) begin
                case (state)
                    IDLE: begin
                        if (bus.Load) begin
                            q_r <= bus.Data;
                        end else if (bus.Start) begin
                            if (amt_sat == '0) begin
                                done_r <= 1'b1;
                            end else begin
                                mode_q <= mode_t'(bus.Mode);
                                cnt    <= amt_sat;
                            end
                        end
                    end
                    SHIFT: begin
                        q_r <= step_q;
                        cnt <= cnt - AMT_W'(1);
                        if (cnt == AMT_W'(1)) done_r <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.Q      = q_r;
    assign bus.SerOut = serout;
    assign bus.Busy   = busy;
    assign bus.Done   = done_r;
endmodule
